// File: rtl/ace_rd_arbiter.sv
// ace_rd_arbiter
//   Two-requester ACE read-channel arbiter (requester 0 = I-cache,
//   requester 1 = D-cache) in front of a single ACE master port. One
//   transaction is outstanding at a time; grants alternate round-robin when
//   both requesters ask in the same cycle.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   req_ar*           per-requester AR request (address/length/snoop packed,
//                     requester i occupies slice i of each flat vector)
//   req_r*            per-requester R valid/ready, shared R data/resp/last
//   m_ar*             master AR channel (m_arid carries the grant index)
//   m_r*, m_rack      master R channel and the ACE read acknowledge
module ace_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [1:0]              req_arvalid,
    output logic [1:0]              req_arready,
    input  logic [2*ADDR_WIDTH-1:0] req_araddr,
    input  logic [2*LEN_WIDTH-1:0]  req_arlen,
    input  logic [7:0]              req_arsnoop,
    output logic [1:0]              req_rvalid,
    input  logic [1:0]              req_rready,
    output logic [DATA_WIDTH-1:0]   req_rdata,
    output logic [3:0]              req_rresp,
    output logic                    req_rlast,

    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic                    m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [LEN_WIDTH-1:0]    m_arlen,
    output logic [3:0]              m_arsnoop,

    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic                    m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [3:0]              m_rresp,
    input  logic                    m_rlast,
    output logic                    m_rack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]            state;
    logic                  grant;
    logic                  last_grant;
    logic                  winner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [3:0]            snoop_q;
    logic                  rid_match;
    logic                  last_beat;

    // On a tie the requester that was not served last wins; otherwise the
    // sole requester wins (only meaningful when some req_arvalid is set).
    always_comb begin
        if (req_arvalid == 2'b11) winner = ~last_grant;
        else                      winner = req_arvalid[1];
    end

    // Beats tagged for the other requester are stale and must not end the burst.
    assign rid_match = (m_rid == grant);
    assign last_beat = m_rvalid && rid_match && req_rready[grant] && m_rlast;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            addr_q     <= '0;
            len_q      <= '0;
            snoop_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_arvalid) begin
                        grant      <= winner;
                        last_grant <= winner;
                        addr_q     <= winner ? req_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                             : req_araddr[ADDR_WIDTH-1:0];
                        len_q      <= winner ? req_arlen[2*LEN_WIDTH-1:LEN_WIDTH]
                                             : req_arlen[LEN_WIDTH-1:0];
                        snoop_q    <= winner ? req_arsnoop[7:4] : req_arsnoop[3:0];
                        state      <= S_ADDR;
                    end
                end
                S_ADDR:  if (m_arready) state <= S_DATA;
                S_DATA:  if (last_beat) state <= S_ACK;
                default: state <= S_IDLE;   // S_ACK: single-cycle acknowledge
            endcase
        end
    end

    // Data path is a straight pass-through; only the handshakes are steered.
    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        req_arready = 2'b00;
        req_rvalid  = 2'b00;
        m_arvalid   = 1'b0;
        m_arid      = 1'b0;
        m_araddr    = '0;
        m_arlen     = '0;
        m_arsnoop   = '0;
        m_rready    = 1'b0;
        m_rack      = 1'b0;
        if (!rst) begin
            case (state)
                S_ADDR: begin
                    m_arvalid          = 1'b1;
                    m_arid             = grant;
                    m_araddr           = addr_q;
                    m_arlen            = len_q;
                    m_arsnoop          = snoop_q;
                    req_arready[grant] = m_arready;
                end
                S_DATA: begin
                    if (rid_match) begin
                        req_rvalid[grant] = m_rvalid;
                        m_rready          = req_rready[grant];
                    end else begin
                        m_rready = 1'b1;   // drain the foreign beat
                    end
                end
                S_ACK:   m_rack = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_rd_arbiter.sv
module tb_ace_rd_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_arvalid;
    logic [1:0]   req_arready;
    logic [63:0]  req_araddr;
    logic [15:0]  req_arlen;
    logic [7:0]   req_arsnoop;
    logic [1:0]   req_rvalid;
    logic [1:0]   req_rready;
    logic [255:0] req_rdata;
    logic [3:0]   req_rresp;
    logic         req_rlast;
    logic         m_arvalid;
    logic         m_arready;
    logic         m_arid;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [3:0]   m_arsnoop;
    logic         m_rvalid;
    logic         m_rready;
    logic         m_rid;
    logic [255:0] m_rdata;
    logic [3:0]   m_rresp;
    logic         m_rlast;
    logic         m_rack;

    int tests_run;
    int tests_failed;

    ace_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsnoop(req_arsnoop),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsnoop(m_arsnoop),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rack(m_rack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled one more time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_arvalid = 2'b11; req_araddr = '0; req_arlen = '0; req_arsnoop = '0;
        req_rready = 2'b11; m_arready = 1'b1; m_rvalid = 1'b0; m_rid = 1'b0;
        m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        step(); step();
        #1;
        tests_run++;
        if ({req_arready, req_rvalid, m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, m_rready, m_rack} !== 52'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0", {req_arready, req_rvalid, m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, m_rready, m_rack});
        end
        req_arvalid = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        req_arvalid = 2'b11; req_araddr = {32'h2000, 32'h1000}; req_arlen = {8'd1, 8'd1};
        req_arsnoop = {4'h2, 4'h1}; m_arready = 1'b1;
        #1;
        tests_run++;
        if ({m_arvalid, req_arready} !== 3'b000) begin
            tests_failed++; $display("FAIL rr_idle_quiet: got %b want 000", {m_arvalid, req_arready});
        end
        step();   // ADDR for requester 0
        #1;
        tests_run++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop} !== {1'b1, 1'b0, 32'h1000, 8'd1, 4'h1}) begin
            tests_failed++; $display("FAIL rr_first_ar: got %h want %h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop}, {1'b1, 1'b0, 32'h1000, 8'd1, 4'h1});
        end
        tests_run++;
        if (req_arready !== 2'b01) begin
            tests_failed++; $display("FAIL rr_first_arready: got %b want 01", req_arready);
        end
        step();   // DATA
        req_arvalid = 2'b10; m_arready = 1'b0; req_rready = 2'b11;
        m_rvalid = 1'b1; m_rid = 1'b0; m_rlast = 1'b0; m_rdata = {8{32'hA5A5_0001}}; m_rresp = 4'h0;
        #1;
        tests_run++;
        if ({req_rvalid, m_rready, m_arvalid} !== 4'b0110) begin
            tests_failed++; $display("FAIL rr_beat1_route: got %b want 0110", {req_rvalid, m_rready, m_arvalid});
        end
        step();
        m_rlast = 1'b1; m_rdata = {8{32'h5A5A_0002}}; m_rresp = 4'h3;
        #1;
        tests_run++;
        if ({req_rlast, req_rresp, req_rdata} !== {1'b1, 4'h3, {8{32'h5A5A_0002}}}) begin
            tests_failed++; $display("FAIL rr_passthrough: got %h want %h", {req_rlast, req_rresp, req_rdata}, {1'b1, 4'h3, {8{32'h5A5A_0002}}});
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if ({m_rack, m_arvalid} !== 2'b10) begin
            tests_failed++; $display("FAIL rr_ack: got %b want 10", {m_rack, m_arvalid});
        end
        step();   // IDLE, arbitrates requester 1
        m_arready = 1'b1;
        #1;
        tests_run++;
        if ({m_rack, m_arvalid} !== 2'b00) begin
            tests_failed++; $display("FAIL rr_gap_idle: got %b want 00", {m_rack, m_arvalid});
        end
        step();   // ADDR for requester 1
        #1;
        tests_run++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, req_arready} !== {1'b1, 1'b1, 32'h2000, 8'd1, 4'h2, 2'b10}) begin
            tests_failed++; $display("FAIL rr_second_ar: got %h want %h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, req_arready}, {1'b1, 1'b1, 32'h2000, 8'd1, 4'h2, 2'b10});
        end
        step();   // DATA
        req_arvalid = 2'b00; m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b1; m_rlast = 1'b1;
        #1;
        tests_run++;
        if (req_rvalid !== 2'b10) begin
            tests_failed++; $display("FAIL rr_second_rvalid: got %b want 10", req_rvalid);
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        step();   // IDLE
    endtask

    task automatic test_ar_stall();
        req_arvalid = 2'b10; req_araddr[63:32] = 32'h3000; req_arlen[15:8] = 8'd3;
        req_arsnoop[7:4] = 4'hB; m_arready = 1'b0;
        step();   // ADDR, stalled
        // Withdraw and scramble the request: the latched copy must hold.
        req_arvalid = 2'b00; req_araddr = '1; req_arlen = '1; req_arsnoop = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, req_arready} !== {1'b1, 1'b1, 32'h3000, 8'd3, 4'hB, 2'b00}) begin
                tests_failed++; $display("FAIL ar_stall_hold[%0d]: got %h want %h", i, {m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, req_arready}, {1'b1, 1'b1, 32'h3000, 8'd3, 4'hB, 2'b00});
            end
            step();
        end
        m_arready = 1'b1;
        #1;
        tests_run++;
        if ({req_arready, m_araddr} !== {2'b10, 32'h3000}) begin
            tests_failed++; $display("FAIL ar_stall_handshake: got %h want %h", {req_arready, m_araddr}, {2'b10, 32'h3000});
        end
        step();   // DATA
        m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b1; m_rlast = 1'b1; req_rready = 2'b11;
        #1;
        tests_run++;
        if ({req_arready, req_rvalid} !== 4'b0010) begin
            tests_failed++; $display("FAIL ar_stall_after: got %b want 0010", {req_arready, req_rvalid});
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if (m_rack !== 1'b1) begin
            tests_failed++; $display("FAIL ar_stall_ack: got %b want 1", m_rack);
        end
        step();   // IDLE
    endtask

    task automatic test_r_stall();
        req_arvalid = 2'b01; req_araddr = {32'h0, 32'h4000}; req_arlen = {8'd0, 8'd1};
        req_arsnoop = 8'h00; m_arready = 1'b1;
        step();   // ADDR
        #1;
        tests_run++;
        if ({m_arid, m_araddr} !== {1'b0, 32'h4000}) begin
            tests_failed++; $display("FAIL r_stall_ar: got %h want %h", {m_arid, m_araddr}, {1'b0, 32'h4000});
        end
        step();   // DATA
        req_arvalid = 2'b00; m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b0; m_rlast = 1'b0;
        req_rready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if ({m_rready, req_rvalid, m_rack} !== 4'b0010) begin
                tests_failed++; $display("FAIL r_stall_hold[%0d]: got %b want 0010", i, {m_rready, req_rvalid, m_rack});
            end
            step();
        end
        req_rready = 2'b01;
        #1;
        tests_run++;
        if ({m_rready, req_rvalid} !== 3'b101) begin
            tests_failed++; $display("FAIL r_stall_release: got %b want 101", {m_rready, req_rvalid});
        end
        step();   // second beat
        m_rlast = 1'b1;
        #1;
        tests_run++;
        if ({m_rready, req_rvalid, m_rack} !== 4'b1010) begin
            tests_failed++; $display("FAIL r_stall_last: got %b want 1010", {m_rready, req_rvalid, m_rack});
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if ({m_rack, req_rvalid} !== 3'b100) begin
            tests_failed++; $display("FAIL r_stall_ack: got %b want 100", {m_rack, req_rvalid});
        end
        step();   // IDLE
        #1;
        tests_run++;
        if (m_rack !== 1'b0) begin
            tests_failed++; $display("FAIL r_stall_ack_once: got %b want 0", m_rack);
        end
    endtask

    task automatic test_drop();
        req_arvalid = 2'b01; req_araddr = {32'h0, 32'h5000}; req_arlen = 16'h0; m_arready = 1'b1;
        step();   // ADDR
        step();   // DATA
        req_arvalid = 2'b00; m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b1; m_rlast = 1'b1;
        req_rready = 2'b00;
        #1;
        tests_run++;
        if ({req_rvalid, m_rready} !== 3'b001) begin
            tests_failed++; $display("FAIL drop_beat: got %b want 001", {req_rvalid, m_rready});
        end
        step();   // must still be DATA
        m_rid = 1'b0; req_rready = 2'b01;
        #1;
        tests_run++;
        if ({req_rvalid, m_rready, m_rack} !== 4'b0110) begin
            tests_failed++; $display("FAIL drop_stays_data: got %b want 0110", {req_rvalid, m_rready, m_rack});
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if (m_rack !== 1'b1) begin
            tests_failed++; $display("FAIL drop_ack: got %b want 1", m_rack);
        end
        step();   // IDLE
    endtask

    task automatic test_single_beat();
        req_arvalid = 2'b10; req_araddr = {32'h6000, 32'h0}; req_arlen = 16'h0;
        req_arsnoop = 8'h70; m_arready = 1'b1;
        step();   // ADDR
        #1;
        tests_run++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop} !== {1'b1, 1'b1, 32'h6000, 8'd0, 4'h7}) begin
            tests_failed++; $display("FAIL single_ar: got %h want %h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop}, {1'b1, 1'b1, 32'h6000, 8'd0, 4'h7});
        end
        step();   // DATA
        req_arvalid = 2'b00; m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b1; m_rlast = 1'b1;
        req_rready = 2'b10;
        #1;
        tests_run++;
        if ({req_rvalid, m_rready, m_rack} !== 4'b1010) begin
            tests_failed++; $display("FAIL single_beat: got %b want 1010", {req_rvalid, m_rready, m_rack});
        end
        step();   // ACK
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if ({m_rack, m_arvalid} !== 2'b10) begin
            tests_failed++; $display("FAIL single_ack: got %b want 10", {m_rack, m_arvalid});
        end
        step();   // IDLE
        #1;
        tests_run++;
        if ({m_rack, m_arvalid, m_rready} !== 3'b000) begin
            tests_failed++; $display("FAIL single_idle: got %b want 000", {m_rack, m_arvalid, m_rready});
        end
    endtask

    task automatic test_reset_mid();
        // Grant requester 0 so that, without the reset, requester 1 would win the next tie.
        req_arvalid = 2'b01; req_araddr = {32'h0, 32'h7000}; req_arlen = {8'd0, 8'd3}; m_arready = 1'b1;
        step();   // ADDR
        step();   // DATA
        req_arvalid = 2'b00; m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 1'b0; m_rlast = 1'b0;
        req_rready = 2'b01;
        #1;
        tests_run++;
        if (req_rvalid !== 2'b01) begin
            tests_failed++; $display("FAIL rst_mid_data: got %b want 01", req_rvalid);
        end
        step();   // second beat, burst still open
        m_rlast = 1'b1; rst = 1'b1;
        step();
        #1;
        tests_run++;
        if ({req_arready, req_rvalid, m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, m_rready, m_rack} !== 52'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got %h want 0", {req_arready, req_rvalid, m_arvalid, m_arid, m_araddr, m_arlen, m_arsnoop, m_rready, m_rack});
        end
        rst = 1'b0; req_arvalid = 2'b11; req_araddr = {32'h9000, 32'h8000}; req_arlen = 16'h0;
        m_arready = 1'b1;
        #1;
        tests_run++;
        if ({m_rack, m_arvalid, req_rvalid} !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_mid_no_ack: got %b want 0000", {m_rack, m_arvalid, req_rvalid});
        end
        step();   // ADDR
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests_run++;
        if ({m_arvalid, m_arid, m_araddr, m_rack} !== {1'b1, 1'b0, 32'h8000, 1'b0}) begin
            tests_failed++; $display("FAIL rst_mid_tie: got %h want %h", {m_arvalid, m_arid, m_araddr, m_rack}, {1'b1, 1'b0, 32'h8000, 1'b0});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_round_robin();
        test_ar_stall();
        test_r_stall();
        test_drop();
        test_single_beat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
